mmio_ctrl: RTL and testbench
============================

Name: mmio_ctrl

Overview:
Memory-mapped I/O controller that sits directly downstream of the multicycle processor's data-memory bus (memwrite, dataadr, writedata). It splits each access between data memory and a small I/O page, and holds the board-facing registers: LEDs, switches, a debounced button and an 8-digit seven-segment scanner. Read data is muxed back to the processor. Data memory itself is external; this block only gates its write enable.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized button level must hold before it is accepted (sim default; board build uses 1000000).
SCAN_DIV, 4, clock cycles each seven-segment digit stays lit.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
memwrite  in  1  processor write strobe
dataadr  in  32  processor byte address
writedata  in  32  processor write data
memreaddata  in  32  read data from data memory
readdata  out  32  read data to processor
dmemwrite  out  1  write enable to data memory
sw  in  16  board switches (asynchronous)
btn  in  1  board push-button (asynchronous, bouncy)
led  out  16  LED register
an  out  8  digit enables, active-low one-hot
seg  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- io_sel = (dataadr[31:8] == 24'hFFFFFF). Address bits [1:0] are ignored.
- dmemwrite = memwrite & ~io_sel. This path is combinational.
- readdata = io_sel ? io_rd : memreaddata. This path is combinational. There is no read strobe, so reads have no side effects.
- I/O map (offset = dataadr[7:0]):
  - 0x00 LED: read/write. led <= writedata[15:0] on the clock edge where memwrite is high. Reads return the value zero-extended.
  - 0x04 SW: read-only. Returns the 2-FF-synchronized sw, zero-extended. Writes are ignored.
  - 0x08 STATUS: bit0 = btn_flag (sticky). bit1 = debounced button level (read-only). Writing 1 to bit0 clears btn_flag (W1C).
  - 0x0C SEG: read/write 32-bit register. Holds eight hex digits; digit i = seg_reg[4i+3:4i].
  - Any other offset: reads return 0, writes are ignored.
- I/O writes take effect on the clock edge where memwrite is high. A read returns the new value from the next cycle onward.
- Button path:
  - btn passes through a 2-FF synchronizer to give btn_s.
  - If btn_s == btn_stable, the debounce counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, btn_stable <= btn_s and the counter clears.
  - So btn_stable updates exactly DEBOUNCE_CYCLES cycles after btn_s first differs, provided btn_s holds. Any shorter pulse is discarded.
- btn_flag:
  - Set on the cycle btn_stable rises 0->1.
  - If a set and a W1C clear happen in the same cycle, the set wins (flag stays 1).
- Seven-segment scanner:
  - A prescaler counts 0..SCAN_DIV-1. On wrap, the 3-bit digit index increments, wrapping 7->0.
  - an = ~(8'b1 << index).
  - seg = active-low hex decode of digit[index]. Examples: 0 -> 1000000, 1 -> 1111001, 7 -> 1111000, 8 -> 0000000, F -> 0001110.
  - an and seg are registered, so they change together one cycle after the index changes.
- Reset values:
  - led = 0, seg_reg = 0, btn_flag = 0, btn_stable = 0.
  - Synchronizers and counters = 0, index = 0.
  - an = 8'hFE, seg = 7'b1000000.
  - Reset mid-scan or mid-debounce discards all progress.

Test Plan:
1. Release reset. Next cycle: led=0, an=FE, seg=1000000, readdata at 0xFFFFFF08 = 0.
2. Write 0x0000ABCD to 0xFFFFFF00 -> dmemwrite stays 0, led=ABCD on the next cycle, readdata at that address = 0x0000ABCD. Then write 7 to address 84 -> dmemwrite=1 for that cycle, led unchanged. Read address 84 with memreaddata=0x7 -> readdata=0x7.
3. Set sw=0x1234 -> readdata at 0xFFFFFF04 stays at its old value for 2 cycles, then reads 0x00001234. Write to 0xFFFFFF04 -> no effect.
4. btn high for 2 cycles, then low -> btn_flag stays 0. btn high and held -> STATUS reads 0x3 exactly 2+DEBOUNCE_CYCLES cycles later. Write 0x1 to 0xFFFFFF08 -> STATUS=0x2. Hold a rising edge aligned with a W1C write -> flag=1.
5. Write 0x76543210 to 0xFFFFFF0C -> an steps FE, FD, FB, ..., 7F, FE, holding SCAN_DIV cycles per step. seg=1000000 when an=FE, 1111001 when an=FD, 1111000 when an=7F.
6. Assert reset during step 5 with index=5 -> on the next edge an=FE, seg_reg=0, led=0.

Source files
------------

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: splits processor accesses between data memory and an I/O page of LED, switch, button and seven-segment registers
module mmio_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic [31:0] memreaddata,
  output logic [31:0] readdata,
  output logic        dmemwrite,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [6:0]  seg
);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  logic          io_sel, io_we, deb_done, w1c;
  logic [5:0]    off;
  logic [31:0]   io_rd, seg_reg;
  logic [15:0]   sw_m, sw_s;
  logic          btn_m, btn_s, btn_stable, btn_flag;
  logic [DW-1:0] cnt;
  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [3:0]    digit;
  logic [6:0]    hex;
  logic          unused_adr;
  assign unused_adr = &dataadr[1:0];
  assign io_sel = dataadr[31:8] == 24'hFFFFFF;
  assign off = dataadr[7:2];
  assign io_we = memwrite & io_sel;
  assign dmemwrite = memwrite & ~io_sel;
  assign readdata = io_sel ? io_rd : memreaddata;
  assign deb_done = (btn_s != btn_stable) && (cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign w1c = io_we && off == 6'd2 && writedata[0];
  assign digit = seg_reg[{idx, 2'b00} +: 4];
  // I/O read mux; unmapped offsets read as zero
  always_comb begin
    io_rd = off == 6'd0 ? {16'b0, led} :
            off == 6'd1 ? {16'b0, sw_s} :
            off == 6'd2 ? {30'b0, btn_stable, btn_flag} :
            off == 6'd3 ? seg_reg : 32'b0;
  end
  // writable I/O registers
  always_ff @(posedge clk) begin
    if (reset) begin
      led <= '0;
      seg_reg <= '0;
    end else begin
      if (io_we && off == 6'd0) led <= writedata[15:0];
      if (io_we && off == 6'd3) seg_reg <= writedata;
    end
  end
  // two-flop synchronizers for the asynchronous board inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_m <= '0;
      sw_s <= '0;
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end
  // debounce: accept a new level only after it holds long enough; a new press beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      btn_stable <= 1'b0;
      btn_flag <= 1'b0;
    end else begin
      cnt <= (btn_s == btn_stable || deb_done) ? '0 : cnt + 1'b1;
      if (deb_done) btn_stable <= btn_s;
      btn_flag <= (deb_done & btn_s) | (btn_flag & ~w1c);
    end
  end
  // active-low hex to seven-segment decode of the selected digit
  always_comb begin
    hex = 7'b1111111;
    case (digit)
      4'h0: hex = 7'b1000000;
      4'h1: hex = 7'b1111001;
      4'h2: hex = 7'b0100100;
      4'h3: hex = 7'b0110000;
      4'h4: hex = 7'b0011001;
      4'h5: hex = 7'b0010010;
      4'h6: hex = 7'b0000010;
      4'h7: hex = 7'b1111000;
      4'h8: hex = 7'b0000000;
      4'h9: hex = 7'b0010000;
      4'hA: hex = 7'b0001000;
      4'hB: hex = 7'b0000011;
      4'hC: hex = 7'b1000110;
      4'hD: hex = 7'b0100001;
      4'hE: hex = 7'b0000110;
      default: hex = 7'b0001110;
    endcase
  end
  // digit scanner: prescaler steps the index, drive outputs registered one cycle behind it
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
      an <= 8'hFE;
      seg <= 7'b1000000;
    end else begin
      pre <= (pre == PW'(SCAN_DIV - 1)) ? '0 : pre + 1'b1;
      if (pre == PW'(SCAN_DIV - 1)) idx <= idx + 3'd1;
      an <= ~(8'b1 << idx);
      seg <= hex;
    end
  end
endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: directed table and sequence checks for mmio_ctrl
module tb_mmio_ctrl;
  logic        clk = 1'b0, reset = 1'b1, memwrite = 1'b0, btn = 1'b0;
  logic [31:0] dataadr = '0, writedata = '0, memreaddata = '0, readdata;
  logic        dmemwrite;
  logic [15:0] sw = '0, led;
  logic [7:0]  an;
  logic [6:0]  seg;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic        mw;
    logic [31:0] adr, wd, mrd, rd;
    logic        dmw;
    logic [15:0] led;
  } vec_t;
  vec_t vt [16];
  logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  mmio_ctrl #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .memreaddata(memreaddata), .readdata(readdata),
    .dmemwrite(dmemwrite), .sw(sw), .btn(btn), .led(led), .an(an), .seg(seg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1;
    dataadr = a;
    writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    dataadr = a;
    #1;
    chk(name, readdata, exp);
  endtask

  initial begin
    vt[0]  = '{1'b0, 32'hFFFFFF08, 32'h0,        32'h0,        32'h0,        1'b0, 16'h0};
    vt[1]  = '{1'b1, 32'hFFFFFF00, 32'h0000ABCD, 32'h0,        32'h0,        1'b0, 16'h0};
    vt[2]  = '{1'b0, 32'hFFFFFF00, 32'h0,        32'h0,        32'h0000ABCD, 1'b0, 16'hABCD};
    vt[3]  = '{1'b1, 32'h00000084, 32'h7,        32'h55,       32'h55,       1'b1, 16'hABCD};
    vt[4]  = '{1'b0, 32'hFFFFFF00, 32'h0,        32'h0,        32'h0000ABCD, 1'b0, 16'hABCD};
    vt[5]  = '{1'b0, 32'h00000084, 32'h0,        32'h7,        32'h7,        1'b0, 16'hABCD};
    vt[6]  = '{1'b1, 32'hFFFFFF0C, 32'h76543210, 32'h0,        32'h0,        1'b0, 16'hABCD};
    vt[7]  = '{1'b0, 32'hFFFFFF0C, 32'h0,        32'h0,        32'h76543210, 1'b0, 16'hABCD};
    vt[8]  = '{1'b0, 32'hFFFFFF10, 32'h0,        32'h0,        32'h0,        1'b0, 16'hABCD};
    vt[9]  = '{1'b1, 32'hFFFFFF20, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 16'hABCD};
    vt[10] = '{1'b0, 32'hFFFFFF03, 32'h0,        32'h0,        32'h0000ABCD, 1'b0, 16'hABCD};
    vt[11] = '{1'b0, 32'hFFFFFE00, 32'h0,        32'h12345678, 32'h12345678, 1'b0, 16'hABCD};
    vt[12] = '{1'b1, 32'hFFFFFF00, 32'hFFFF0000, 32'h0,        32'h0000ABCD, 1'b0, 16'hABCD};
    vt[13] = '{1'b0, 32'hFFFFFF00, 32'h0,        32'h0,        32'h0,        1'b0, 16'h0};
    vt[14] = '{1'b1, 32'hFFFFFF02, 32'h00001111, 32'h0,        32'h0,        1'b0, 16'h0};
    vt[15] = '{1'b0, 32'hFFFFFF00, 32'h0,        32'h0,        32'h00001111, 1'b0, 16'h1111};

    tick(3);
    reset = 1'b0;
    tick();
    chk("rst_led", {16'b0, led}, 32'h0);
    chk("rst_an", {24'b0, an}, 32'hFE);
    chk("rst_seg", {25'b0, seg}, 32'h40);
    rd_chk("rst_status", 32'hFFFFFF08, 32'h0);

    for (int i = 0; i < 16; i++) begin
      memwrite = vt[i].mw;
      dataadr = vt[i].adr;
      writedata = vt[i].wd;
      memreaddata = vt[i].mrd;
      #1;
      chk($sformatf("vec%0d_rd", i), readdata, vt[i].rd);
      chk($sformatf("vec%0d_dmw", i), {31'b0, dmemwrite}, {31'b0, vt[i].dmw});
      chk($sformatf("vec%0d_led", i), {16'b0, led}, {16'b0, vt[i].led});
      tick();
      memwrite = 1'b0;
    end
    memreaddata = '0;

    sw = 16'h1234;
    rd_chk("sw_sync0", 32'hFFFFFF04, 32'h0);
    tick();
    rd_chk("sw_sync1", 32'hFFFFFF04, 32'h0);
    tick();
    rd_chk("sw_sync2", 32'hFFFFFF04, 32'h1234);
    wr(32'hFFFFFF04, 32'h0);
    rd_chk("sw_ro", 32'hFFFFFF04, 32'h1234);

    btn = 1'b1;
    tick(2);
    btn = 1'b0;
    tick(8);
    rd_chk("btn_short", 32'hFFFFFF08, 32'h0);
    btn = 1'b1;
    tick(5);
    rd_chk("btn_early", 32'hFFFFFF08, 32'h0);
    tick();
    rd_chk("btn_accept", 32'hFFFFFF08, 32'h3);
    wr(32'hFFFFFF08, 32'h1);
    rd_chk("btn_w1c", 32'hFFFFFF08, 32'h2);
    btn = 1'b0;
    tick(8);
    rd_chk("btn_release", 32'hFFFFFF08, 32'h0);
    btn = 1'b1;
    tick(5);
    rd_chk("btn_pre_race", 32'hFFFFFF08, 32'h0);
    wr(32'hFFFFFF08, 32'h1);
    rd_chk("btn_set_wins", 32'hFFFFFF08, 32'h3);
    wr(32'hFFFFFF08, 32'h1);
    rd_chk("btn_w1c2", 32'hFFFFFF08, 32'h2);
    btn = 1'b0;

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    wr(32'hFFFFFF0C, 32'h76543210);
    for (int k = 1; k <= 36; k++) begin
      logic [31:0] v;
      logic [7:0]  ea;
      int          j;
      v = 32'h76543210;
      j = ((k - 1) / 4) % 8;
      ea = ~(8'd1 << j);
      chk($sformatf("scan%0d_an", k), {24'b0, an}, {24'b0, ea});
      chk($sformatf("scan%0d_seg", k), {25'b0, seg}, {25'b0, hex7[v[4*j +: 4]]});
      tick();
    end

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    wr(32'hFFFFFF0C, 32'h76543210);
    wr(32'hFFFFFF00, 32'h00005A5A);
    tick(19);
    chk("mid_an", {24'b0, an}, 32'hDF);
    chk("mid_led", {16'b0, led}, 32'h5A5A);
    reset = 1'b1;
    tick();
    chk("mrst_an", {24'b0, an}, 32'hFE);
    chk("mrst_seg", {25'b0, seg}, 32'h40);
    chk("mrst_led", {16'b0, led}, 32'h0);
    reset = 1'b0;
    rd_chk("mrst_segreg", 32'hFFFFFF0C, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
